// File: rtl/smem_bank_unit.sv
// Banked shared-memory scratchpad: per-bank fixed-priority grants serialize conflicts; reads return one merged response, writes are posted.
// Optional build macro SMEM_READ_BCAST_EN: pending reads of the granted read's bank/row are serviced in the same cycle.
module smem_bank_unit #(
  parameter int NUM_REQS   = 4,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 256,
  parameter int WORD_SIZE  = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQS-1:0]               req_valid,
  input  logic [NUM_REQS-1:0]               req_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]     req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQS*WORD_SIZE*8-1:0]   req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag,
  output logic [NUM_REQS-1:0]               req_ready,
  output logic [NUM_REQS-1:0]               rsp_valid,
  output logic [NUM_REQS*WORD_SIZE*8-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]              rsp_tag,
  input  logic                              rsp_ready
);

  localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
  localparam int unsigned ROW_BITS  = $clog2(BANK_WORDS);
  localparam int unsigned WORD_BITS = WORD_SIZE * 8;
  localparam int unsigned LANES     = NUM_REQS;

  typedef enum logic [1:0] {IDLE, ACCESS, RSP} state_t;

  state_t state_q, state_d;

  logic [NUM_REQS-1:0]                  pend_q, pend_d;
  logic [NUM_REQS-1:0]                  read_mask_q, read_mask_d;
  logic [NUM_REQS-1:0]                  rw_q, rw_d;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0]   byteen_q, byteen_d;
  logic [NUM_REQS-1:0][BANK_BITS-1:0]   bank_q, bank_d;
  logic [NUM_REQS-1:0][ROW_BITS-1:0]    row_q, row_d;
  logic [NUM_REQS-1:0][WORD_BITS-1:0]   data_q, data_d;
  logic [TAG_WIDTH-1:0]                 tag_q, tag_d;

  logic [NUM_REQS-1:0]                  grant;
  logic [NUM_REQS-1:0]                  serve;
  logic [NUM_REQS-1:0][WORD_BITS-1:0]   rd_word;
  logic [NUM_REQS-1:0]                  ready_c;

  logic [WORD_BITS-1:0] mem [NUM_BANKS][BANK_WORDS];

  // Address bits above bank+row are intentionally discarded (capacity wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  // A lane wins its bank when no lower-indexed pending lane targets the same bank.
  always_comb begin
    grant = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      grant[l] = pend_q[l];
      for (int unsigned j = 0; j < l; j++) begin
        if (pend_q[j] && (bank_q[j] == bank_q[l])) begin
          grant[l] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    serve = grant;
`ifdef SMEM_READ_BCAST_EN
    for (int unsigned l = 0; l < LANES; l++) begin
      if (pend_q[l] && !rw_q[l]) begin
        for (int unsigned j = 0; j < LANES; j++) begin
          if (grant[j] && !rw_q[j] && (bank_q[j] == bank_q[l]) && (row_q[j] == row_q[l])) begin
            serve[l] = 1'b1;
          end
        end
      end
    end
`endif
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      rd_word[l] = mem[bank_q[l]][row_q[l]];
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    read_mask_d = read_mask_q;
    rw_d        = rw_q;
    byteen_d    = byteen_q;
    bank_d      = bank_q;
    row_d       = row_q;
    data_d      = data_q;
    tag_d       = tag_q;
    ready_c     = '0;

    case (state_q)
      IDLE: begin
        ready_c = '1;
        if (|req_valid) begin
          state_d     = ACCESS;
          pend_d      = req_valid;
          read_mask_d = req_valid & ~req_rw;
          // Walk lanes high to low so the lowest valid lane's tag is the one kept.
          for (int unsigned i = 0; i < LANES; i++) begin
            int unsigned l;
            l = LANES - 1 - i;
            if (req_valid[l]) begin
              rw_d[l]     = req_rw[l];
              byteen_d[l] = req_byteen[l*WORD_SIZE +: WORD_SIZE];
              bank_d[l]   = req_addr[l*ADDR_WIDTH +: BANK_BITS];
              row_d[l]    = req_addr[l*ADDR_WIDTH + BANK_BITS +: ROW_BITS];
              data_d[l]   = req_data[l*WORD_BITS +: WORD_BITS];
              tag_d       = req_tag[l*TAG_WIDTH +: TAG_WIDTH];
            end
          end
        end
      end

      ACCESS: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (serve[l] && !rw_q[l]) begin
            data_d[l] = rd_word[l];
          end
        end
        pend_d = pend_q & ~serve;
        if (pend_d == '0) begin
          state_d = (|read_mask_q) ? RSP : IDLE;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      read_mask_q <= '0;
      rw_q        <= '0;
      byteen_q    <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      data_q      <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      read_mask_q <= read_mask_d;
      rw_q        <= rw_d;
      byteen_q    <= byteen_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
    end
  end

  // Storage is not reset; reset forces IDLE, which suppresses all writes.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (grant[l] && rw_q[l]) begin
          for (int unsigned b = 0; b < WORD_SIZE; b++) begin
            if (byteen_q[l][b]) begin
              mem[bank_q[l]][row_q[l]][b*8 +: 8] <= data_q[l][b*8 +: 8];
            end
          end
        end
      end
    end
  end

  assign req_ready = reset ? '0 : ready_c;
  assign rsp_valid = (state_q == RSP) ? read_mask_q : '0;
  assign rsp_data  = data_q;
  assign rsp_tag   = tag_q;

endmodule

// File: doc/smem_bank_unit.md
Name: smem_bank_unit

Overview:
- Banked shared-memory scratchpad that sits directly downstream of the data-bus splitter.
- Consumes the per-lane shared-memory request stream and returns one merged per-warp response on the shared-memory response stream.
- Serializes bank conflicts with per-bank fixed-priority grant. Reads return one merged response; writes are posted.

Parameters:
- NUM_REQS, 4, lanes per request (equals NUM_THREADS).
- NUM_BANKS, 4, power of 2, ≤ NUM_REQS.
- BANK_WORDS, 256, words per bank, power of 2.
- WORD_SIZE, 4, bytes per word.
- ADDR_WIDTH, 30, word-address width.
- TAG_WIDTH, 8, request tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQS  per-lane request valid.
- req_rw  in  NUM_REQS  1 = write.
- req_byteen  in  NUM_REQS*WORD_SIZE  per-lane byte enables.
- req_addr  in  NUM_REQS*ADDR_WIDTH  per-lane word address.
- req_data  in  NUM_REQS*WORD_SIZE*8  per-lane write data.
- req_tag  in  NUM_REQS*TAG_WIDTH  per-lane tag; all valid lanes of one warp carry the same tag.
- req_ready  out  NUM_REQS  per-lane ready.
- rsp_valid  out  NUM_REQS  per-lane read-response valid mask.
- rsp_data  out  NUM_REQS*WORD_SIZE*8  per-lane read data.
- rsp_tag  out  TAG_WIDTH  response tag.
- rsp_ready  in  1  consumer ready.

Behaviour:
- Bank = addr[log2(NUM_BANKS)-1:0].
- Row = next log2(BANK_WORDS) bits. Higher address bits are ignored, so addresses wrap modulo the total capacity.
- State machine states: IDLE, ACCESS, RSP.
- IDLE:
  - req_ready is all ones (forced to 0 while reset is asserted).
  - On any req_valid bit, latch all valid lanes into the pending mask with their addr, rw, byteen and data.
  - Also record read_mask = valid & ~rw.
  - Latch tag from the lowest-indexed valid lane.
  - Go to ACCESS.
- ACCESS:
  - req_ready = 0.
  - Each cycle, each bank grants its lowest-indexed pending lane.
  - Write: update the bytes selected by byteen at the clock edge.
  - Read: capture the word into that lane's data register at the clock edge.
  - Clear the granted lanes' pending bits.
  - When the pending mask would become empty: if read_mask is nonzero, go to RSP; otherwise go to IDLE.
- Same-word collisions are resolved in ascending lane order. A read by a higher lane returns data written by a lower lane in the same batch.
- RSP:
  - rsp_valid = read_mask; rsp_data and rsp_tag are held stable.
  - When rsp_ready is sampled high, go to IDLE.
  - rsp_ready low holds the state indefinitely. No new request is accepted before the response is taken.
- Latency: accept at cycle 0; N cycles of ACCESS, where N is the maximum lane count on any single bank; rsp_valid high from cycle N+1.
- Reset values:
  - State = IDLE.
  - rsp_valid = 0, pending mask = 0, read_mask = 0.
  - rsp_data and rsp_tag = 0.
  - Memory contents are not reset.
- Reset asserted mid-ACCESS or mid-RSP aborts the batch immediately. No response is emitted and partial writes remain.
- Lanes with req_valid = 0 are ignored entirely, including their addr and data.

Optional Feature:
- Macro: SMEM_READ_BCAST_EN.
- When defined, in the same ACCESS cycle every pending read lane whose bank and row equal the granted lane's bank and row is also serviced and cleared, provided the granted lane is a read.
- Write lanes are never merged.
- When undefined, each lane is serviced individually, strictly one lane per bank per cycle.

Test Plan:
- Conflict-free read:
  - Stimulus: 4 lanes read addresses 0, 1, 2, 3 with tag 0x5A.
  - Required: req_ready = 4'b1111 at accept; exactly one ACCESS cycle; rsp_valid = 4'b1111 at cycle 2; rsp_tag = 0x5A; data matches preloaded values.
- Full conflict:
  - Stimulus: 4 lanes read addresses 0, 4, 8, 12 (all bank 0).
  - Required: 4 ACCESS cycles; rsp_valid at cycle 5; lane data correct.
  - With SMEM_READ_BCAST_EN, reads of 0, 0, 0, 4 take 2 cycles.
- Mixed batch:
  - Stimulus: lane0 writes 0xDEADBEEF to addr 8 with byteen 4'b0011; lane1 reads addr 8.
  - Required: lane1 returns 0x????BEEF with the old upper bytes; rsp_valid = 4'b0010.
- Write-only batch:
  - Stimulus: write-only batch on lanes 0 and 2.
  - Required: rsp_valid never asserts; req_ready returns high one cycle after the last ACCESS cycle.
- Backpressure:
  - Stimulus: hold rsp_ready = 0 for 10 cycles with another request pending.
  - Required: rsp_valid, rsp_data and rsp_tag stable; req_ready = 0 throughout; the second batch is accepted in the cycle after the handshake.
- Reset mid-ACCESS:
  - Stimulus: assert reset during a 4-cycle conflict batch.
  - Required: rsp_valid = 0 and req_ready = 0 immediately; after release, IDLE with req_ready all ones.
